// File: rtl/wb_regfile_pkg.sv
// ---------------------------------------------------------------------------
// wb_regfile_pkg
//   Shared constants for the write-back stage / register file slice.
//   DEF_DATA_W / DEF_ADDR_W : default register width and index width
//   ZERO_WORD               : all-zero data word
//   REG_ZERO                : hardwired-zero register index
//   WRITE_EN / WRITE_DIS    : write-enable levels
//   READ_EN  / READ_DIS     : read-enable levels
// ---------------------------------------------------------------------------
package wb_regfile_pkg;

   localparam int DEF_DATA_W = 32;
   localparam int DEF_ADDR_W = 5;

   localparam logic [DEF_DATA_W-1:0] ZERO_WORD = '0;
   localparam logic [DEF_ADDR_W-1:0] REG_ZERO  = '0;

   localparam logic WRITE_EN  = 1'b1;
   localparam logic WRITE_DIS = 1'b0;
   localparam logic READ_EN   = 1'b1;
   localparam logic READ_DIS  = 1'b0;

endpackage : wb_regfile_pkg

// File: rtl/wb_regfile_if.sv
// ---------------------------------------------------------------------------
// wb_regfile_if
//   Bus between the pipeline (master) and the write-back/register-file stage
//   (slave).
//   i_stall, i_flush                     : pipeline control
//   i_wreg, i_wreg_addr, i_wreg_data     : MEM-stage write-back request
//   i_re1, i_raddr1 / o_rdata1           : decode read port 1
//   i_re2, i_raddr2 / o_rdata2           : decode read port 2
//   o_wb_valid                           : WB latch holds a pending write
// ---------------------------------------------------------------------------
interface wb_regfile_if
   import wb_regfile_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W
);

   logic              i_stall;
   logic              i_flush;
   logic              i_wreg;
   logic [ADDR_W-1:0] i_wreg_addr;
   logic [DATA_W-1:0] i_wreg_data;
   logic              i_re1;
   logic [ADDR_W-1:0] i_raddr1;
   logic [DATA_W-1:0] o_rdata1;
   logic              i_re2;
   logic [ADDR_W-1:0] i_raddr2;
   logic [DATA_W-1:0] o_rdata2;
   logic              o_wb_valid;

   modport master (
      output i_stall, i_flush,
      output i_wreg, i_wreg_addr, i_wreg_data,
      output i_re1, i_raddr1, i_re2, i_raddr2,
      input  o_rdata1, o_rdata2, o_wb_valid
   );

   modport slave (
      input  i_stall, i_flush,
      input  i_wreg, i_wreg_addr, i_wreg_data,
      input  i_re1, i_raddr1, i_re2, i_raddr2,
      output o_rdata1, o_rdata2, o_wb_valid
   );

endinterface : wb_regfile_if

// File: rtl/wb_regfile_array.sv
// ---------------------------------------------------------------------------
// regfile_array
//   2**ADDR_W x DATA_W architectural register storage: one synchronous write
//   port, two asynchronous read ports, asynchronous clear. Index 0 is never
//   written, so it always reads zero.
//   clk, rst_n            : clock (rising edge), async active-low clear
//   i_we/i_waddr/i_wdata  : write port
//   i_raddr1 / o_rdata1   : read port 1
//   i_raddr2 / o_rdata2   : read port 2
// ---------------------------------------------------------------------------
module regfile_array
   import wb_regfile_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_waddr,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic [ADDR_W-1:0] i_raddr1,
   output logic [DATA_W-1:0] o_rdata1,
   input  logic [ADDR_W-1:0] i_raddr2,
   output logic [DATA_W-1:0] o_rdata2
);

   localparam int unsigned DEPTH = 2**ADDR_W;

   logic [DATA_W-1:0] r_mem [DEPTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if ((i_we == WRITE_EN) && (i_waddr != ADDR_W'(REG_ZERO))) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata1 = r_mem[i_raddr1];
   assign o_rdata2 = r_mem[i_raddr2];

endmodule : regfile_array

// File: rtl/wb_regfile.sv
// ---------------------------------------------------------------------------
// wb_regfile
//   Write-back stage and architectural register file. Captures the MEM-stage
//   write request in a MEM/WB latch, commits it to the array on the following
//   unstalled edge, and serves two combinational read ports that bypass the
//   pending latch so decode never sees stale data.
//   clk    : core clock, rising edge
//   rst_n  : asynchronous reset, active low
//   bus    : wb_regfile_if.slave (stall/flush, write request, read ports,
//            o_wb_valid)
// ---------------------------------------------------------------------------
module wb_regfile
   import wb_regfile_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic        clk,
   input  logic        rst_n,
   wb_regfile_if.slave bus
);

   logic              r_valid;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_data;

   logic              w_commit;
   logic [DATA_W-1:0] w_arr1;
   logic [DATA_W-1:0] w_arr2;

   // Flush only discards the incoming request; the write already sitting in
   // the latch still commits on this edge unless the pipeline is stalled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= 1'b0;
         r_addr  <= '0;
         r_data  <= '0;
      end else if (bus.i_flush) begin
         r_valid <= 1'b0;
      end else if (!bus.i_stall) begin
         r_valid <= (bus.i_wreg == WRITE_EN) && (bus.i_wreg_addr != ADDR_W'(REG_ZERO));
         r_addr  <= bus.i_wreg_addr;
         r_data  <= bus.i_wreg_data;
      end
   end

   assign w_commit = r_valid && !bus.i_stall;

   regfile_array #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_array (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_we     (w_commit),
      .i_waddr  (r_addr),
      .i_wdata  (r_data),
      .i_raddr1 (bus.i_raddr1),
      .o_rdata1 (w_arr1),
      .i_raddr2 (bus.i_raddr2),
      .o_rdata2 (w_arr2)
   );

   function automatic logic [DATA_W-1:0] read_sel(
      input logic              re,
      input logic [ADDR_W-1:0] raddr,
      input logic [DATA_W-1:0] arr
   );
      if (re != READ_EN || raddr == ADDR_W'(REG_ZERO)) begin
         return '0;
      end else if (r_valid && (r_addr == raddr)) begin
         return r_data;
      end else begin
         return arr;
      end
   endfunction

   always_comb begin
      bus.o_rdata1 = read_sel(bus.i_re1, bus.i_raddr1, w_arr1);
      bus.o_rdata2 = read_sel(bus.i_re2, bus.i_raddr2, w_arr2);
   end

   assign bus.o_wb_valid = r_valid;

endmodule : wb_regfile

// File: tb/tb_wb_regfile.sv
// ---------------------------------------------------------------------------
// tb_wb_regfile
//   Directed and randomized checks of wb_regfile against a reference model
//   consisting of an architectural array plus a queue of pending writes.
// ---------------------------------------------------------------------------
module tb_wb_regfile;
   import wb_regfile_pkg::*;

   logic clk;
   logic rst_n;

   wb_regfile_if bus_if ();

   wb_regfile dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [4:0]  a;
      logic [31:0] d;
   } wr_t;

   logic [31:0] m_arch [32];
   wr_t         m_pend [$];

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 32; i++) m_arch[i] = '0;
      m_pend.delete();
   endtask

   // One rising edge as seen by the architecture: the oldest pending write
   // retires unless stalled; flush empties the pending slot; otherwise a
   // nonzero-index request becomes the new pending write.
   task automatic model_step(input logic st, input logic fl, input logic we,
                             input logic [4:0] wa, input logic [31:0] wd);
      wr_t w;
      if (!st && m_pend.size() > 0) begin
         w = m_pend.pop_front();
         m_arch[w.a] = w.d;
      end
      if (fl) m_pend.delete();
      else if (!st) begin
         m_pend.delete();
         if (we && wa != 0) begin
            w.a = wa; w.d = wd;
            m_pend.push_back(w);
         end
      end
   endtask

   function automatic logic [31:0] model_rd(input logic re, input logic [4:0] a);
      if (!re || a == 0) return 32'h0;
      if (m_pend.size() > 0 && m_pend[$].a == a) return m_pend[$].d;
      return m_arch[a];
   endfunction

   // Present a request, take one clock edge, return the bus to idle.
   task automatic cyc(input logic st, input logic fl, input logic we,
                      input logic [4:0] wa, input logic [31:0] wd);
      bus_if.i_stall     = st;
      bus_if.i_flush     = fl;
      bus_if.i_wreg      = we;
      bus_if.i_wreg_addr = wa;
      bus_if.i_wreg_data = wd;
      @(posedge clk);
      model_step(st, fl, we, wa, wd);
      #1;
      bus_if.i_stall = 1'b0;
      bus_if.i_flush = 1'b0;
      bus_if.i_wreg  = WRITE_DIS;
   endtask

   task automatic idle();
      cyc(1'b0, 1'b0, WRITE_DIS, 5'd0, 32'h0);
   endtask

   // Read both ports and compare against a fixed expectation.
   task automatic rd(input string tag, input logic re1, input logic [4:0] a1,
                     input logic [31:0] e1, input logic re2, input logic [4:0] a2,
                     input logic [31:0] e2);
      bus_if.i_re1 = re1; bus_if.i_raddr1 = a1;
      bus_if.i_re2 = re2; bus_if.i_raddr2 = a2;
      #1;
      chk({tag, ".p1"}, bus_if.o_rdata1, e1);
      chk({tag, ".p2"}, bus_if.o_rdata2, e2);
   endtask

   task automatic chk_valid(input string tag, input logic exp);
      chk({tag, ".valid"}, {31'h0, bus_if.o_wb_valid}, {31'h0, exp});
   endtask

   initial begin
      rst_n = 1'b0;
      bus_if.i_stall = 1'b0; bus_if.i_flush = 1'b0;
      bus_if.i_wreg = WRITE_EN; bus_if.i_wreg_addr = 5'd5; bus_if.i_wreg_data = 32'hFFFF_FFFF;
      bus_if.i_re1 = READ_EN; bus_if.i_raddr1 = 5'd5;
      bus_if.i_re2 = READ_EN; bus_if.i_raddr2 = 5'd5;
      model_reset();

      // 1. writes presented during reset must leave no trace
      repeat (3) @(posedge clk);
      #1;
      bus_if.i_wreg = WRITE_DIS;
      rst_n = 1'b1;
      #1;
      chk_valid("reset", 1'b0);
      for (int i = 0; i < 32; i++)
         rd($sformatf("reset.r%0d", i), READ_EN, 5'(i), 32'h0, READ_EN, 5'(31 - i), 32'h0);

      // 2. bypass then array
      cyc(1'b0, 1'b0, WRITE_EN, 5'd5, 32'hDEAD_BEEF);
      chk_valid("w5.n1", 1'b1);
      rd("w5.n1", READ_EN, 5'd5, 32'hDEAD_BEEF, READ_EN, 5'd5, 32'hDEAD_BEEF);
      idle();
      idle();
      chk_valid("w5.n3", 1'b0);
      rd("w5.n3", READ_EN, 5'd5, 32'hDEAD_BEEF, READ_EN, 5'd6, 32'h0);

      // 3. r0 write dropped; disabled read returns zero
      cyc(1'b0, 1'b0, WRITE_EN, 5'd0, 32'h1234_5678);
      chk_valid("w0", 1'b0);
      rd("w0.a", READ_EN, 5'd0, 32'h0, READ_EN, 5'd0, 32'h0);
      idle();
      rd("w0.b", READ_EN, 5'd0, 32'h0, READ_EN, 5'd5, 32'hDEAD_BEEF);
      rd("re1off", READ_DIS, 5'd5, 32'h0, READ_EN, 5'd5, 32'hDEAD_BEEF);

      // 4. back-to-back writes to the same index
      cyc(1'b0, 1'b0, WRITE_EN, 5'd7, 32'h1);
      rd("w7.n1", READ_EN, 5'd7, 32'h1, READ_EN, 5'd7, 32'h1);
      cyc(1'b0, 1'b0, WRITE_EN, 5'd7, 32'h2);
      rd("w7.n2", READ_EN, 5'd7, 32'h2, READ_EN, 5'd7, 32'h2);
      idle();
      idle();
      rd("w7.drain", READ_EN, 5'd7, 32'h2, READ_EN, 5'd5, 32'hDEAD_BEEF);

      // 5. stall holds the latch and keeps bypassing it
      cyc(1'b0, 1'b0, WRITE_EN, 5'd9, 32'hA);
      for (int i = 0; i < 3; i++) begin
         cyc(1'b1, 1'b0, WRITE_EN, 5'd9, 32'hB);
         chk_valid($sformatf("stall%0d", i), 1'b1);
         rd($sformatf("stall%0d", i), READ_EN, 5'd9, 32'hA, READ_EN, 5'd9, 32'hA);
      end
      cyc(1'b0, 1'b0, WRITE_EN, 5'd9, 32'hB);
      rd("stall.rel", READ_EN, 5'd9, 32'hB, READ_EN, 5'd9, 32'hB);
      // flushing away 0xB exposes what was committed on release
      cyc(1'b1, 1'b1, WRITE_DIS, 5'd0, 32'h0);
      chk_valid("stall.fl", 1'b0);
      rd("stall.arr", READ_EN, 5'd9, 32'hA, READ_EN, 5'd7, 32'h2);

      // 6. flush keeps the latched commit, drops the incoming request
      cyc(1'b0, 1'b0, WRITE_EN, 5'd3, 32'h55);
      cyc(1'b0, 1'b1, WRITE_EN, 5'd4, 32'h66);
      chk_valid("flush", 1'b0);
      rd("flush", READ_EN, 5'd3, 32'h55, READ_EN, 5'd4, 32'h0);
      idle();
      rd("flush.b", READ_EN, 5'd3, 32'h55, READ_EN, 5'd4, 32'h0);

      // randomized traffic checked against the model
      for (int n = 0; n < 400; n++) begin
         logic        st, fl, we, r1, r2;
         logic [4:0]  wa, a1, a2;
         logic [31:0] wd;
         r1 = ($urandom_range(0, 9) != 0);
         r2 = ($urandom_range(0, 9) != 0);
         a1 = 5'($urandom_range(0, 31));
         a2 = ($urandom_range(0, 3) == 0) ? a1 : 5'($urandom_range(0, 31));
         if (m_pend.size() > 0 && $urandom_range(0, 1) == 1) a1 = m_pend[$].a;
         rd($sformatf("rnd%0d", n), r1, a1, model_rd(r1, a1), r2, a2, model_rd(r2, a2));
         chk_valid($sformatf("rnd%0d", n), m_pend.size() > 0);
         st = ($urandom_range(0, 9) == 0);
         fl = ($urandom_range(0, 19) == 0);
         we = ($urandom_range(0, 3) != 0);
         wa = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
         wd = $urandom;
         cyc(st, fl, we, wa, wd);
      end

      // 6b. asynchronous reset mid-stream clears everything at once
      cyc(1'b0, 1'b0, WRITE_EN, 5'd12, 32'hCAFE_F00D);
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      chk_valid("arst", 1'b0);
      for (int i = 0; i < 32; i++)
         rd($sformatf("arst.r%0d", i), READ_EN, 5'(i), 32'h0, READ_EN, 5'(i), 32'h0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      rd("arst.post", READ_EN, 5'd12, 32'h0, READ_EN, 5'd7, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_wb_regfile
